seq_borrow_lookahead_subtractor: RTL and testbench
==================================================

Name: seq_borrow_lookahead_subtractor

Overview:
- Multi-cycle subtractor: computes DIFF = A - B - Bin over WIDTH bits.
- Processes one 4-bit chunk per cycle through a borrow-lookahead slice, carrying the borrow in a register between chunks.
- It is the subtract-direction counterpart of the team's 4-bit carry-lookahead adder.
- Used in the datapath where an area-cheap wide subtract with a start/done handshake is acceptable.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4; elaboration error otherwise.
- NCHUNK, WIDTH/4, derived localparam: number of chunk cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; accepted only when busy=0.
- a  input  WIDTH  minuend, sampled at acceptance.
- b  input  WIDTH  subtrahend, sampled at acceptance.
- bin  input  1  borrow-in, sampled at acceptance.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when diff/bout become valid.
- diff  output  WIDTH  result; held until the next accepted start.
- bout  output  1  final borrow-out (1 means unsigned A < B + Bin); held like diff.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - State IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Internal operand registers, chunk index and borrow register all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at an edge: latch a, b, bin; set chunk index k=0 and borrow register = bin; busy=1; go to RUN.
- RUN, one chunk per cycle (k = 0..NCHUNK-1, LSB chunk first):
  - Slice inputs: a[4k+3:4k], b[4k+3:4k] and the borrow register.
  - Per bit: g = ~a & b, p = ~(a ^ b), d = a ^ b ^ bin_i.
  - Chunk borrow-out is computed by lookahead: Bo = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0·Bi. It is not rippled.
  - Write the chunk difference into the result shift register; borrow register takes Bo.
  - After chunk NCHUNK-1: go to DONE.
- DONE (exactly one cycle):
  - diff and bout update; done=1; busy=0; next state IDLE.
  - A start sampled in this cycle is accepted exactly as in IDLE (back-to-back ops allowed).
- Latency: start accepted at edge E0; done high in the cycle following edge E(NCHUNK+1). For WIDTH=16, done is asserted 5 edges after acceptance.
- Throughput: one op per NCHUNK+1 cycles.
- Handshake and input rules:
  - start while busy=1 is ignored. No queueing, no error.
  - a, b and bin may change freely after acceptance.
  - diff/bout keep the previous result during RUN; they are not partially updated.
- Wrap-around: the result is modulo 2^WIDTH. Underflow is reported only via bout.
- Reset mid-operation: the operation is aborted immediately and all outputs return to reset values. No done pulse.

Optional Feature:
- Macro: SUB_FLAGS_EN.
- When defined:
  - Extra outputs zero (1 bit) and ovf (1 bit), registered and updated together with diff.
  - zero = (diff == 0).
  - ovf = signed two's-complement overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
  - Both outputs reset to 0.
- When undefined: the ports do not exist and no flag logic is built.

Decomposition:
- Package sub_pkg:
  - CHUNK_W = 4.
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module nibble_borrow_lookahead:
  - Purely combinational 4-bit slice.
  - Inputs x[3:0], y[3:0], bi; outputs d[3:0], bo.
  - Instantiated once and reused each RUN cycle.
- Top module: FSM, operand registers, chunk counter, borrow register, result register.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> after 5 edges done=1 for one cycle, diff=0x1000, bout=0, busy low in the done cycle.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. With SUB_FLAGS_EN: zero=0, ovf=0.
- a=0x8000, b=0x0000, bin=1 -> diff=0x7FFF, bout=0. With SUB_FLAGS_EN: ovf=1. Also a=b=0x5A5A, bin=0 -> diff=0, zero=1.
- Start pulsed again on the cycle after acceptance with different operands -> ignored, first result delivered unchanged. Then start held through the done cycle -> second op accepted back-to-back, its done arrives 5 edges later.
- Borrow across all chunks: a=0x1000, b=0x0001 -> diff=0x0FFF, bout=0. Checks borrow propagation through chunks 0 to 2.
- rst_n asserted in the 2nd RUN cycle -> busy, done, diff and bout go to 0 immediately. No done pulse follows. A fresh start after release works normally.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and constants for the sequential borrow-lookahead subtractor.
package sub_pkg;

  localparam int unsigned CHUNK_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/nibble_borrow_lookahead.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = x - y - bi, bo = borrow out.
module nibble_borrow_lookahead
  import sub_pkg::*;
(
  input  logic [CHUNK_W-1:0] x_i,
  input  logic [CHUNK_W-1:0] y_i,
  input  logic               bi_i,
  output logic [CHUNK_W-1:0] d_o,
  output logic               bo_o
);

  logic [CHUNK_W-1:0] g;
  logic [CHUNK_W-1:0] p;
  logic [CHUNK_W-1:0] bw;

  assign g = ~x_i & y_i;
  assign p = ~(x_i ^ y_i);

  // Every internal borrow is flattened so no term depends on a previous bit's borrow.
  assign bw[0] = bi_i;
  assign bw[1] = g[0] | (p[0] & bi_i);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi_i);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi_i);
  assign bo_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bi_i);

  assign d_o = x_i ^ y_i ^ bw;

endmodule

// File: rtl/seq_borrow_lookahead_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one nibble per cycle, start/done handshake.
// Optional zero/ovf flag outputs are built when SUB_FLAGS_EN is defined.
module seq_borrow_lookahead_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero_o,
  output logic             ovf_o
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : gen_width_check
    $error("WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [KW-1:0]      k_q, k_d;
  logic               brw_q, brw_d;
  logic               bout_q, bout_d;
  logic               done_q, done_d;
  logic [CHUNK_W-1:0] slice_d;
  logic               slice_bo;
  logic               accept;

  nibble_borrow_lookahead u_slice (
    .x_i  (a_q[k_q*CHUNK_W +: CHUNK_W]),
    .y_i  (b_q[k_q*CHUNK_W +: CHUNK_W]),
    .bi_i (brw_q),
    .d_o  (slice_d),
    .bo_o (slice_bo)
  );

`ifdef SUB_FLAGS_EN
  logic zero_q, zero_d, ovf_q, ovf_d;
`endif

  assign accept = start_i && (state_q == StIdle || state_q == StDone);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    k_d     = k_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SUB_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: ;
      StRun: begin
        // LSB chunk first: new nibble enters at the top, older ones shift down.
        res_d = (res_q >> CHUNK_W) | (WIDTH'(slice_d) << (WIDTH - CHUNK_W));
        brw_d = slice_bo;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NCHUNK - 1)) state_d = StDone;
      end
      StDone: begin
        diff_d  = res_q;
        bout_d  = brw_q;
        done_d  = 1'b1;
        state_d = StIdle;
`ifdef SUB_FLAGS_EN
        zero_d  = (res_q == '0);
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);
`endif
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      a_d     = a_i;
      b_d     = b_i;
      brw_d   = bin_i;
      k_d     = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      k_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      k_q     <= k_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

`ifdef SUB_FLAGS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero_o = zero_q;
  assign ovf_o  = ovf_q;
`endif

  assign busy_o = (state_q == StRun);
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;

endmodule

// File: tb/tb_seq_borrow_lookahead_subtractor.sv
// Randomised scoreboard bench for seq_borrow_lookahead_subtractor (WIDTH=16).
module tb_seq_borrow_lookahead_subtractor;

  localparam int unsigned W      = 16;
  localparam time         PERIOD = 10;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [W-1:0] a_i, b_i;
  logic         bin_i;
  logic         busy_o, done_o, bout_o;
  logic [W-1:0] diff_o;
`ifdef SUB_FLAGS_EN
  logic         zero_o, ovf_o;
`endif

  seq_borrow_lookahead_subtractor #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .diff_o  (diff_o),
    .bout_o  (bout_o)
`ifdef SUB_FLAGS_EN
    ,
    .zero_o  (zero_o),
    .ovf_o   (ovf_o)
`endif
  );

  always #(PERIOD / 2) clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
    time          t_done;
    bit           chk_busy;
  } exp_t;

  exp_t         q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Plain arithmetic reference: 17-bit subtraction, borrow is the sign bit.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                 input time t_acc, input bit chk_busy);
    exp_t       e;
    logic [W:0] r;
    r          = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff     = r[W-1:0];
    e.bout     = r[W];
    e.zero     = (e.diff == '0);
    e.ovf      = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    e.t_done   = t_acc + 5 * PERIOD + PERIOD / 2;
    e.chk_busy = chk_busy;
    return e;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      last_diff = '0;
      last_bout = 1'b0;
    end else if (done_o) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", 32'(diff_o), 32'(e.diff));
        chk("bout", 32'(bout_o), 32'(e.bout));
        chk("done_time", 32'($time), 32'(e.t_done));
        if (e.chk_busy) chk("busy_in_done", 32'(busy_o), 32'd0);
`ifdef SUB_FLAGS_EN
        chk("zero", 32'(zero_o), 32'(e.zero));
        chk("ovf", 32'(ovf_o), 32'(e.ovf));
`endif
        last_diff = e.diff;
        last_bout = e.bout;
      end
    end else begin
      chk("hold_diff", 32'(diff_o), 32'(last_diff));
      chk("hold_bout", 32'(bout_o), 32'(last_bout));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      #1;
      if (q.size() == 0) break;
    end
    chk("done_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk_i);
    start_i = 1'b1; a_i = a; b_i = b; bin_i = bin;
    @(posedge clk_i);
    q.push_back(model(a, b, bin, $time, 1'b1));
    #1 start_i = 1'b0;
  endtask

  // Start stays high from the first acceptance through the DONE cycle.
  task automatic b2b(input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                     input logic [W-1:0] a2, input logic [W-1:0] b2, input logic c2);
    @(negedge clk_i);
    start_i = 1'b1; a_i = a1; b_i = b1; bin_i = c1;
    @(posedge clk_i);
    q.push_back(model(a1, b1, c1, $time, 1'b0));
    #1 a_i = a2; b_i = b2; bin_i = c2;
    repeat (5) @(posedge clk_i);
    q.push_back(model(a2, b2, c2, $time, 1'b1));
    #1 start_i = 1'b0;
  endtask

  initial begin
    #(20000 * PERIOD);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_diff", 32'(diff_o), 32'd0);
    chk("rst_bout", 32'(bout_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    do_op(16'h1234, 16'h0234, 1'b0); wait_idle();
    do_op(16'h0000, 16'h0001, 1'b0); wait_idle();
    do_op(16'h8000, 16'h0000, 1'b1); wait_idle();
    do_op(16'h5A5A, 16'h5A5A, 1'b0); wait_idle();
    do_op(16'h1000, 16'h0001, 1'b0); wait_idle();

    // Start pulsed during RUN with other operands must be ignored.
    do_op(16'hBEEF, 16'h1111, 1'b1);
    @(negedge clk_i);
    start_i = 1'b1; a_i = 16'h0001; b_i = 16'hFFFF; bin_i = 1'b0;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_idle();

    b2b(16'h4321, 16'h1234, 1'b0, 16'h0F0F, 16'hF0F0, 1'b1);
    wait_idle();

    // Abort in the second RUN cycle.
    @(negedge clk_i);
    start_i = 1'b1; a_i = 16'h7777; b_i = 16'h0123; bin_i = 1'b0;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_diff", 32'(diff_o), 32'd0);
    chk("abort_bout", 32'(bout_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    do_op(16'hA5A5, 16'h5A5A, 1'b1); wait_idle();

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb, ra2, rb2;
      logic         rc, rc2;
      ra  = W'($urandom); rb  = W'($urandom); rc  = 1'($urandom);
      ra2 = W'($urandom); rb2 = W'($urandom); rc2 = 1'($urandom);
      if ($urandom_range(0, 3) == 0) b2b(ra, rb, rc, ra2, rb2, rc2);
      else do_op(ra, rb, rc);
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
